serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Receive side of the team's serial shift link: deserializes a framed bit stream back into
//   WIDTH-bit parallel words. Frame format: start(0), data, even parity, stop(1).
//   Sits between the serial pin/strobe domain logic and word-level consumers.
//   Output is a single-entry holding register with a valid/ready handshake.
// PARAMETERS
//   WIDTH      5   data bits per frame (>=2)
//   MSB_FIRST  1   1: first data bit is po[WIDTH-1] (left-shift order); 0: first bit is po[0]
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      reset, synchronous, active-high
//   si         in   1      serial data; idle level 1
//   si_en      in   1      bit strobe; si sampled only on cycles with si_en=1
//   po         out  WIDTH  received word; stable while po_valid=1
//   po_valid   out  1      po holds an unconsumed word
//   po_ready   in   1      consumer accepts; transfer when po_valid & po_ready
//   parity_err out  1      1-cycle pulse: frame with bad parity dropped
//   frame_err  out  1      1-cycle pulse: stop bit sampled 0, frame dropped
//   overrun    out  1      1-cycle pulse: good frame dropped, holding register full
//   busy       out  1      1 whenever FSM is not IDLE
// BEHAVIOUR
//   Reset: po=0, po_valid=0, all pulses 0, busy=0, FSM=IDLE, bit count=0, shift reg=0.
//   rst wins over every other input, including mid-frame; partial frame discarded, no pulses.
//   FSM (advances only on si_en=1; when si_en=0, state, shift reg and count hold):
//     IDLE   : si=0 -> DATA, cnt=0; si=1 -> stay
//     DATA   : shift si in (MSB_FIRST=1: sh<={sh[W-2:0],si}; else sh<={si,sh[W-1:1]});
//              cnt++; after WIDTH-th bit (cnt==WIDTH-1) -> PARITY
//     PARITY : latch par_ok = (^sh ^ si)==0 -> STOP
//     STOP   : -> IDLE always; si=1 & par_ok -> frame good; si=0 -> frame_err;
//              si=1 & !par_ok -> parity_err. frame_err takes precedence over parity_err.
//   Good-frame commit, evaluated in the STOP-sampling cycle, visible next cycle:
//     - po_valid=0, or po_valid=1 & po_ready=1 -> po<=sh, po_valid<=1 (no bubble, no overrun)
//     - po_valid=1 & po_ready=0 -> new word dropped, po unchanged, overrun pulses
//   Consumer: po_valid & po_ready with no commit -> po_valid<=0 next cycle; po holds last value.
//   Latency: po_valid rises exactly 1 clk after the cycle sampling the stop bit.
//   Error pulses are registered and assert in the same cycle po_valid would have risen.
//   Back-to-back frames: a start bit may be sampled on the very next si_en after stop.
//   A start bit is detected only in IDLE; si=0 on stop is not treated as a new start.
//   po_ready ignored while po_valid=0. busy=0 in IDLE, 1 in DATA/PARITY/STOP.
// TESTING (WIDTH=5, MSB_FIRST=1, si_en=1 every cycle unless stated)
//   1 Serial 0,1,0,1,1,0,1,1 (start, 10110, par=1, stop), po_ready=1
//     -> po=5'b10110, po_valid=1 one cycle after stop, no error pulses.
//   2 Same frame, si_en=1 every 3rd cycle only -> identical po, bits between strobes ignored.
//   3 Two good frames 10110 then 01001 back-to-back, po_ready=0 throughout
//     -> po stays 10110, overrun pulses once; then po_ready=1 -> po_valid drops next cycle.
//   4 Frame 10110 with parity bit 0 -> parity_err pulse, po_valid stays 0;
//     frame 10110 with stop=0 -> frame_err pulse only (no parity_err).
//   5 rst=1 after 3 data bits, then clean frame 00111 (par=1)
//     -> all outputs 0 during reset, subsequent po=5'b00111 with no errors.
//   6 MSB_FIRST=0, data bits 1,0,1,1,0 (par=1) -> po=5'b01101; po_ready pulsed in the
//     commit cycle of the next frame -> new word loads, no overrun.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial_frame_rx serial input, word handshake and status bundle
// Purpose: groups the serial link, the word output handshake and the status pulses of serial_frame_rx.
// Signals:
//   si, si_en         serial data (idle 1) and bit strobe, driven by the link side
//   po, po_valid      received word and its valid flag, driven by the receiver
//   po_ready          consumer accept, driven by the consumer
//   parity_err        1-cycle pulse, frame with bad parity dropped
//   frame_err         1-cycle pulse, stop bit sampled 0, frame dropped
//   overrun           1-cycle pulse, good frame dropped because holding register full
//   busy              receiver is inside a frame
// Modports: slave = receiver, master = link driver / consumer.
interface serial_frame_rx_if #(
  parameter int WIDTH = 5
);
  logic             si;
  logic             si_en;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport slave (
    input  si, si_en, po_ready,
    output po, po_valid, parity_err, frame_err, overrun, busy
  );

  modport master (
    output si, si_en, po_ready,
    input  po, po_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - framed serial receiver with single-entry word holding register
// Purpose: deserializes start(0) / WIDTH data / even parity / stop(1) frames into WIDTH-bit words.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   serial_frame_rx_if.slave: si/si_en in, po/po_valid/po_ready word handshake,
//         parity_err/frame_err/overrun pulses, busy
// Parameters: WIDTH data bits per frame (>=2); MSB_FIRST 1 = first data bit lands in po[WIDTH-1].
module serial_frame_rx #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1
) (
  input logic                 clk,
  input logic                 rst,
  serial_frame_rx_if.slave    bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic             par_ok;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             overrun_q;

  always_comb begin
    sh_next = sh;
    if (MSB_FIRST) sh_next = {sh[WIDTH-2:0], bus.si};
    else           sh_next = {bus.si, sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sh           <= '0;
      par_ok       <= 1'b0;
      po_q         <= '0;
      po_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;

      // Consumer take; a commit further down in the same cycle overrides this.
      if (po_valid_q && bus.po_ready) po_valid_q <= 1'b0;

      if (bus.si_en) begin
        case (state)
          ST_IDLE: begin
            if (!bus.si) begin
              state <= ST_DATA;
              cnt   <= '0;
            end
          end
          ST_DATA: begin
            sh  <= sh_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= ST_PARITY;
          end
          ST_PARITY: begin
            // Even parity: data ones plus parity bit must be even.
            par_ok <= ~((^sh) ^ bus.si);
            state  <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!bus.si) begin
              frame_err_q <= 1'b1;
            end else if (!par_ok) begin
              parity_err_q <= 1'b1;
            end else if (!po_valid_q || bus.po_ready) begin
              // Register empty or being drained this cycle: load without a bubble.
              po_q       <= sh;
              po_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.po         = po_q;
  assign bus.po_valid   = po_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - randomized self-checking bench for serial_frame_rx
module tb_serial_frame_rx;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  logic si;
  logic si_en;
  logic po_ready;

  always #5 clk = ~clk;

  serial_frame_rx_if #(.WIDTH(W)) bm ();
  serial_frame_rx_if #(.WIDTH(W)) bl ();

  assign bm.si       = si;
  assign bm.si_en    = si_en;
  assign bm.po_ready = po_ready;
  assign bl.si       = si;
  assign bl.si_en    = si_en;
  assign bl.po_ready = po_ready;

  serial_frame_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
  serial_frame_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));

  int checks = 0;
  int errors = 0;

  // Reference: word in first-bit-first order, holding register and pulses.
  logic [W-1:0] m_po;
  logic         m_valid;
  logic         m_busy;
  logic         m_pe, m_fe, m_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // kind: 0 nothing, 1 good frame ends, 2 parity error, 3 frame error
  task automatic step(input logic r, input logic s, input logic se, input logic rd,
                      input int kind, input logic [W-1:0] w, input logic busy_nxt);
    logic old;
    rst = r; si = s; si_en = se; po_ready = rd;
    @(posedge clk);
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    if (r) begin
      m_po = '0; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      old = m_valid;
      if (old && rd) m_valid = 1'b0;
      case (kind)
        1: if (!old || rd) begin m_po = w; m_valid = 1'b1; end else m_ov = 1'b1;
        2: m_pe = 1'b1;
        3: m_fe = 1'b1;
        default: ;
      endcase
      m_busy = busy_nxt;
    end
    #1;
    check("msb_po",        32'(bm.po),         32'(m_po));
    check("msb_po_valid",  32'(bm.po_valid),   32'(m_valid));
    check("msb_parity",    32'(bm.parity_err), 32'(m_pe));
    check("msb_frame",     32'(bm.frame_err),  32'(m_fe));
    check("msb_overrun",   32'(bm.overrun),    32'(m_ov));
    check("msb_busy",      32'(bm.busy),       32'(m_busy));
    check("lsb_po",        32'(bl.po),         32'(rev(m_po)));
    check("lsb_po_valid",  32'(bl.po_valid),   32'(m_valid));
    check("lsb_parity",    32'(bl.parity_err), 32'(m_pe));
    check("lsb_frame",     32'(bl.frame_err),  32'(m_fe));
    check("lsb_overrun",   32'(bl.overrun),    32'(m_ov));
    check("lsb_busy",      32'(bl.busy),       32'(m_busy));
  endtask

  // ready mode: 0 hold 0, 1 hold 1, 2 random, 3 high only on the stop strobe
  function automatic logic rdy(input int mode, input logic at_stop);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return at_stop;
    endcase
  endfunction

  // d: word as the MSB-first receiver sees it; d[W-1] goes on the wire first.
  task automatic send_frame(input logic [W-1:0] d, input logic bad_par, input logic bad_stop,
                            input int g, input int mode);
    logic b [W+3];
    int   kind;
    b[0] = 1'b0;
    for (int i = 0; i < W; i++) b[1+i] = d[W-1-i];
    b[W+1] = (^d) ^ bad_par;
    b[W+2] = ~bad_stop;
    for (int k = 0; k < W + 3; k++) begin
      for (int j = 1; j < g; j++)
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy(mode, 1'b0), 0, '0, m_busy);
      kind = (k == W + 2) ? (bad_stop ? 3 : (bad_par ? 2 : 1)) : 0;
      step(1'b0, b[k], 1'b1, rdy(mode, k == W + 2), kind, d, k != W + 2);
    end
  endtask

  task automatic idle(input int n, input int mode);
    logic se;
    for (int i = 0; i < n; i++) begin
      se = 1'($urandom_range(0, 1));
      step(1'b0, se ? 1'b1 : 1'($urandom_range(0, 1)), se, rdy(mode, 1'b0), 0, '0, 1'b0);
    end
  endtask

  initial begin
    m_po = '0; m_valid = 1'b0; m_busy = 1'b0;
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    rst = 1'b1; si = 1'b1; si_en = 1'b0; po_ready = 1'b0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0, '0, 1'b0);
    idle(2, 0);

    // 1: basic frame 10110
    send_frame(5'b10110, 1'b0, 1'b0, 1, 1);
    check("t1_po_const", 32'(bm.po), 32'h16);
    check("t1_lsb_const", 32'(bl.po), 32'h0d);
    idle(2, 1);

    // 2: strobe every third cycle
    send_frame(5'b10110, 1'b0, 1'b0, 3, 1);
    check("t2_po_const", 32'(bm.po), 32'h16);
    idle(2, 1);

    // 3: back-to-back with consumer stalled, then drain
    send_frame(5'b10110, 1'b0, 1'b0, 1, 0);
    send_frame(5'b01001, 1'b0, 1'b0, 1, 0);
    check("t3_po_kept", 32'(bm.po), 32'h16);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, '0, 1'b0);
    check("t3_drained", 32'(bm.po_valid), 32'h0);
    idle(1, 0);

    // 4: parity error, then stop error
    send_frame(5'b10110, 1'b1, 1'b0, 1, 0);
    send_frame(5'b10110, 1'b0, 1'b1, 1, 0);
    idle(2, 0);

    // 5: reset mid-frame
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
    send_frame(5'b00111, 1'b0, 1'b0, 1, 0);
    check("t5_po_const", 32'(bm.po), 32'h07);

    // 6: stalled word replaced by a ready pulse in the next commit cycle
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, '0, 1'b0);
    send_frame(5'b10110, 1'b0, 1'b0, 1, 0);
    check("t6_lsb_const", 32'(bl.po), 32'h0d);
    send_frame(5'b01001, 1'b0, 1'b0, 1, 3);
    check("t6_lsb_next", 32'(bl.po), 32'h12);
    idle(2, 1);

    // Random frames, gaps, strobe spacing and consumer behaviour
    for (int n = 0; n < 60; n++) begin
      send_frame(W'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 $urandom_range(1, 3), $urandom_range(0, 3));
      idle($urandom_range(0, 2), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
